// File: rtl/ext_bus_ctrl_if.sv
// Handshake and pad-side signal bundle for the external bus controller.
// master: the core / pad ring side. slave: the controller itself.
interface ext_bus_ctrl_if;
    // core request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    // core response
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    // pad ring
    logic        bus_rdy_i;
    logic [31:0] bus_data_recv_b;
    logic        bus_en_o;
    logic        bus_we_o;
    logic [1:0]  bus_size_o;
    logic [15:0] bus_addr_o;
    logic [31:0] bus_data_drv_b;
    logic        dbus_o_en_b;
    logic        dbus_i_en_b;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output bus_rdy_i, bus_data_recv_b,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  bus_en_o, bus_we_o, bus_size_o, bus_addr_o, bus_data_drv_b,
        input  dbus_o_en_b, dbus_i_en_b
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  bus_rdy_i, bus_data_recv_b,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output bus_en_o, bus_we_o, bus_size_o, bus_addr_o, bus_data_drv_b,
        output dbus_o_en_b, dbus_i_en_b
    );
endinterface

// File: rtl/ext_bus_ctrl.sv
// Core-side controller for the 16-bit address / 32-bit data external bus.
// Turns single load/store requests into a four-phase bus_en/bus_rdy
// transaction, synchronises bus_rdy_i, replicates store lanes, extracts and
// extends load data, and reports misalignment / illegal size / timeout.
module ext_bus_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic          clk_i,
    input  logic          a_reset_l_i,
    ext_bus_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // WAIT ends with an error once TIMEOUT_CYC wait cycles have elapsed
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_TURN
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] rdy_sync_q, rdy_sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lat_we_q, lat_we_d;
    logic                   lat_uns_q, lat_uns_d;
    logic [1:0]             size_q, size_d;
    logic [15:0]            addr_q, addr_d;
    logic [31:0]            drv_q, drv_d;
    logic                   en_q, en_d;
    logic                   we_q, we_d;
    logic                   oen_q, oen_d;
    logic                   ien_q, ien_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;

    logic rdy_s;
    logic req_illegal;

    assign rdy_s = rdy_sync_q[SYNC_STAGES-1];

    assign req_illegal = (bus.req_size == 2'b11) ||
                         ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    function automatic logic [31:0] lane_replicate(input logic [1:0] size,
                                                   input logic [31:0] wdata);
        case (size)
            2'b00:   lane_replicate = {4{wdata[7:0]}};
            2'b01:   lane_replicate = {2{wdata[15:0]}};
            default: lane_replicate = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] recv);
        logic [31:0] sh;
        logic [15:0] half;
        sh   = recv >> {lane, 3'b000};
        half = lane[1] ? recv[31:16] : recv[15:0];
        case (size)
            2'b00:   load_extract = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_extract = uns ? {16'h0000, half} : {{16{half[15]}}, half};
            default: load_extract = recv;
        endcase
    endfunction

    // next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        rdy_sync_d  = {rdy_sync_q[SYNC_STAGES-2:0], bus.bus_rdy_i};
        cnt_d       = '0;
        lat_we_d    = lat_we_q;
        lat_uns_d   = lat_uns_q;
        size_d      = size_q;
        addr_d      = addr_q;
        drv_d       = drv_q;
        en_d        = en_q;
        we_d        = we_q;
        oen_d       = oen_q;
        ien_d       = ien_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    lat_we_d  = bus.req_we;
                    lat_uns_d = bus.req_unsigned;
                    size_d    = bus.req_size;
                    addr_d    = bus.req_addr;
                    drv_d     = lane_replicate(bus.req_size, bus.req_wdata);
                    if (req_illegal) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        en_d    = 1'b1;
                        we_d    = bus.req_we;
                        oen_d   = bus.req_we;
                        ien_d   = ~bus.req_we;
                    end
                end
            end
            ST_WAIT: begin
                if (rdy_s) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lat_we_q ? '0
                                : load_extract(size_q, lat_uns_q, addr_q[1:0], bus.bus_data_recv_b);
                    en_d  = 1'b0;
                    we_d  = 1'b0;
                    oen_d = 1'b0;
                    ien_d = 1'b0;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    en_d  = 1'b0;
                    we_d  = 1'b0;
                    oen_d = 1'b0;
                    ien_d = 1'b0;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_TURN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // ready is registered so it is low in reset; it tracks IDLE & ~rdy_s exactly
        req_ready_d = (state_d == ST_IDLE) && !rdy_sync_d[SYNC_STAGES-1];
    end

    // state, synchroniser, counter and output registers
    always_ff @(posedge clk_i or negedge a_reset_l_i) begin
        if (!a_reset_l_i) begin
            state_q     <= ST_IDLE;
            rdy_sync_q  <= '0;
            cnt_q       <= '0;
            lat_we_q    <= 1'b0;
            lat_uns_q   <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            drv_q       <= '0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            oen_q       <= 1'b0;
            ien_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_sync_q  <= rdy_sync_d;
            cnt_q       <= cnt_d;
            lat_we_q    <= lat_we_d;
            lat_uns_q   <= lat_uns_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            drv_q       <= drv_d;
            en_q        <= en_d;
            we_q        <= we_d;
            oen_q       <= oen_d;
            ien_q       <= ien_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.bus_en_o       = en_q;
    assign bus.bus_we_o       = we_q;
    assign bus.bus_size_o     = size_q;
    assign bus.bus_addr_o     = addr_q;
    assign bus.bus_data_drv_b = drv_q;
    assign bus.dbus_o_en_b    = oen_q;
    assign bus.dbus_i_en_b    = ien_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl: a vector table of single transactions
// plus hand-written sequences for stuck ready and mid-transaction reset.
module tb_ext_bus_ctrl;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TO   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ext_bus_ctrl_if bif();

    ext_bus_ctrl #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)) dut (
        .clk_i       (clk),
        .a_reset_l_i (rst_n),
        .bus         (bif)
    );

    // rdy_dly: rdy raised at the sample where bus_en_o has been seen rdy_dly
    // times; -1 = never. exp_en: number of cycles bus_en_o is high.
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] recv;
        int          rdy_dly;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_drv;
        int          exp_en;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input vec_t v);
        bif.req_valid    = 1'b1;
        bif.req_we       = v.we;
        bif.req_size     = v.size;
        bif.req_unsigned = v.uns;
        bif.req_addr     = v.addr;
        bif.req_wdata    = v.wdata;
    endtask

    task automatic run_txn(input vec_t v, input string tag, input bit hold_rdy);
        int  w;
        int  en_cyc;
        bit  got_rsp;
        bit  unstable;
        drive_req(v);
        w = 0;
        while (!bif.req_ready && w < 50) begin
            step();
            w++;
        end
        check($sformatf("%s ready", tag), 32'(bif.req_ready), 32'd1);
        step();                         // accept edge
        bif.req_valid = 1'b0;
        en_cyc   = 0;
        got_rsp  = 1'b0;
        unstable = 1'b0;
        for (int k = 0; k < 40 && !got_rsp; k++) begin
            if (bif.rsp_valid) begin
                got_rsp = 1'b1;
                check($sformatf("%s err", tag), 32'(bif.rsp_err), 32'(v.exp_err));
                check($sformatf("%s rdata", tag), bif.rsp_rdata, v.exp_rdata);
                check($sformatf("%s done_enables", tag),
                      32'({bif.bus_en_o, bif.bus_we_o, bif.dbus_o_en_b, bif.dbus_i_en_b}), 32'd0);
                check($sformatf("%s en_cycles", tag), 32'(en_cyc), 32'(v.exp_en));
                check($sformatf("%s wait_stable", tag), 32'(unstable), 32'd0);
            end else begin
                if (bif.bus_en_o) begin
                    en_cyc++;
                    if (bif.bus_we_o !== v.we || bif.bus_addr_o !== v.addr ||
                        bif.bus_size_o !== v.size || bif.dbus_o_en_b !== v.we ||
                        bif.dbus_i_en_b !== !v.we || (v.we && bif.bus_data_drv_b !== v.exp_drv))
                        unstable = 1'b1;
                    if (v.rdy_dly >= 0 && en_cyc == v.rdy_dly) begin
                        bif.bus_rdy_i       = 1'b1;
                        bif.bus_data_recv_b = v.recv;
                    end
                end
                step();
            end
        end
        check($sformatf("%s rsp_seen", tag), 32'(got_rsp), 32'd1);
        step();                         // TURN
        check($sformatf("%s turn", tag),
              32'({bif.rsp_valid, bif.bus_en_o, bif.bus_we_o, bif.dbus_o_en_b, bif.dbus_i_en_b}), 32'd0);
        if (!hold_rdy) begin
            bif.bus_rdy_i       = 1'b0;
            bif.bus_data_recv_b = '0;
        end
    endtask

    vec_t vecs[13];
    vec_t v;
    bit   flag;
    int   w;

    initial begin
        //            we    size   uns   addr      wdata         recv          dly err  rdata         drv           en
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h00000000,  3, 1'b0, 32'h00000000, 32'hDEADBEEF, 5};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 16'h0003, 32'h00000000, 32'h80123456,  2, 1'b0, 32'hFFFFFF80, 32'h0,        4};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 16'h0003, 32'h00000000, 32'h80123456,  1, 1'b0, 32'h00000080, 32'h0,        3};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 16'h0102, 32'h123456A5, 32'h00000000,  1, 1'b0, 32'h00000000, 32'hA5A5A5A5, 3};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 16'h0202, 32'h0000BEEF, 32'h00000000,  2, 1'b0, 32'h00000000, 32'hBEEFBEEF, 4};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 16'h0006, 32'h00000000, 32'h9ABC1234,  1, 1'b0, 32'hFFFF9ABC, 32'h0,        3};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 16'h0004, 32'h00000000, 32'h12348765,  2, 1'b0, 32'h00008765, 32'h0,        4};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 16'h0008, 32'h00000000, 32'hCAFEF00D,  3, 1'b0, 32'hCAFEF00D, 32'h0,        5};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 16'h0001, 32'h00000000, 32'h00007F00,  1, 1'b0, 32'h0000007F, 32'h0,        3};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 16'h0001, 32'h00001234, 32'h00000000, -1, 1'b1, 32'h00000000, 32'h0,        0};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 16'h0002, 32'h00000000, 32'h00000000, -1, 1'b1, 32'h00000000, 32'h0,        0};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 16'h0000, 32'h00000000, 32'h00000000, -1, 1'b1, 32'h00000000, 32'h0,        0};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 16'h000C, 32'h00000000, 32'h55AA55AA, -1, 1'b1, 32'h00000000, 32'h0,        8};

        bif.req_valid       = 1'b0;
        bif.req_we          = 1'b0;
        bif.req_size        = 2'b00;
        bif.req_unsigned    = 1'b0;
        bif.req_addr        = '0;
        bif.req_wdata       = '0;
        bif.bus_rdy_i       = 1'b0;
        bif.bus_data_recv_b = '0;

        // reset state
        repeat (3) step();
        check("reset ctrl", 32'({bif.req_ready, bif.rsp_valid, bif.rsp_err, bif.bus_en_o,
                                 bif.bus_we_o, bif.dbus_o_en_b, bif.dbus_i_en_b, bif.bus_size_o}), 32'd0);
        check("reset addr", 32'(bif.bus_addr_o), 32'd0);
        check("reset drv", bif.bus_data_drv_b, 32'd0);
        check("reset rdata", bif.rsp_rdata, 32'd0);
        rst_n = 1'b1;
        step();
        check("ready after reset", 32'(bif.req_ready), 32'd1);

        for (int i = 0; i < 13; i++)
            run_txn(vecs[i], $sformatf("v%0d", i), 1'b0);

        // rdy stuck high after a transaction blocks the next request
        run_txn(vecs[0], "stuck", 1'b1);
        v = vecs[7];
        drive_req(v);
        flag = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bif.req_ready || bif.bus_en_o) flag = 1'b1;
            step();
        end
        check("stuck held_off", 32'(flag), 32'd0);
        bif.req_valid = 1'b0;
        bif.bus_rdy_i = 1'b0;
        w = 0;
        while (!bif.req_ready && w < 10) begin
            step();
            w++;
        end
        check("stuck release_lat", 32'(w), 32'(SYNC));
        run_txn(vecs[7], "after_stuck", 1'b0);

        // reset while waiting aborts without a response
        v = vecs[12];
        drive_req(v);
        w = 0;
        while (!bif.req_ready && w < 50) begin
            step();
            w++;
        end
        step();
        bif.req_valid = 1'b0;
        repeat (3) step();
        check("midreset in_wait", 32'(bif.bus_en_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset ctrl", 32'({bif.req_ready, bif.rsp_valid, bif.rsp_err, bif.bus_en_o,
                                    bif.bus_we_o, bif.dbus_o_en_b, bif.dbus_i_en_b, bif.bus_size_o}), 32'd0);
        check("midreset addr", 32'(bif.bus_addr_o), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bif.rsp_valid || bif.bus_en_o) flag = 1'b1;
            step();
        end
        check("midreset no_rsp", 32'(flag), 32'd0);
        check("midreset idle_ready", 32'(bif.req_ready), 32'd1);
        run_txn(vecs[1], "after_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
